cipher_bus_responder: RTL and testbench

Slave end of the cipher bus: accepts one 128-bit block per handshake from the bus master (the testbench's encrypt/decrypt tasks, or a host adapter), sequences the AES round datapath over Nr rounds in either direction, and returns the result with a one-cycle valid strobe. It sits between the cipher bus and the combinational round function. It reads round keys by index from the key-expansion store, which raises key-ready on the key bus.

---
 rtl/cipher_bus_responder.sv | 174 +++++++++++++++++
 tb/tb_cipher_bus_responder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_bus_responder.sv
// Cipher-bus slave: accepts one block, runs key whitening plus Nr AES rounds through an
// external round function, and returns the result. `CIPHER_BUS_SKID_EN adds a one-entry skid.
module cipher_bus_responder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] i_data,
  input  logic         i_data_valid,
  input  logic         i_ende,
  input  logic         i_enable,
  input  logic [1:0]   i_key_mode,
  input  logic         i_key_ready,
  output logic         o_ready,
  output logic [127:0] o_data,
  output logic         o_data_valid,
  output logic         o_abort,
  output logic [3:0]   o_key_idx,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_rnd_state,
  output logic         o_rnd_ende,
  output logic         o_rnd_last,
  input  logic [127:0] i_rnd_result
);

  typedef enum logic [1:0] {StIdle, StWhiten, StRound} state_e;

  state_e       fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic         ende_q, ende_d;
  logic [3:0]   nr_q, nr_d;
  logic [127:0] data_d;
  logic         valid_d, abort_d, ready_d;
  logic         mode_ok, busy, accept, done;

`ifdef CIPHER_BUS_SKID_EN
  logic         skid_valid_q, skid_valid_d;
  logic [127:0] skid_data_q, skid_data_d;
  logic         skid_ende_q, skid_ende_d;
  logic [1:0]   skid_mode_q, skid_mode_d;
`endif

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  assign mode_ok = (i_key_mode != 2'b11);
  assign busy    = (fsm_q != StIdle);
  assign accept  = o_ready & i_data_valid & i_enable & mode_ok;
  assign done    = (fsm_q == StRound) && (rnd_q == nr_q) && i_enable;

  assign o_rnd_state = blk_q;
  assign o_rnd_ende  = ende_q;
  assign o_rnd_last  = (fsm_q == StRound) && (rnd_q == nr_q);

  always_comb begin
    o_key_idx = 4'd0;
    case (fsm_q)
      StWhiten: o_key_idx = ende_q ? nr_q : 4'd0;
      StRound:  o_key_idx = ende_q ? nr_q - rnd_q : rnd_q;
      default:  o_key_idx = 4'd0;
    endcase
  end

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    ende_d  = ende_q;
    nr_d    = nr_q;
    data_d  = o_data;
    valid_d = 1'b0;
    abort_d = 1'b0;
`ifdef CIPHER_BUS_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ende_d  = skid_ende_q;
    skid_mode_d  = skid_mode_q;
`endif
    if (busy && !i_key_ready) begin
      // Losing the key schedule discards the block, even one completing on this edge.
      fsm_d   = StIdle;
      rnd_d   = 4'd0;
      abort_d = 1'b1;
`ifdef CIPHER_BUS_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
      if (busy && i_enable) begin
        if (fsm_q == StWhiten) begin
          blk_d = blk_q ^ i_round_key;
          rnd_d = 4'd1;
          fsm_d = StRound;
        end else begin
          blk_d = i_rnd_result;
          rnd_d = rnd_q + 4'd1;
          if (done) begin
            data_d  = i_rnd_result;
            valid_d = 1'b1;
            rnd_d   = 4'd0;
            fsm_d   = StIdle;
          end
        end
      end
      if (accept && (!busy || done)) begin
        blk_d  = i_data;
        ende_d = i_ende;
        nr_d   = nr_of(i_key_mode);
        rnd_d  = 4'd0;
        fsm_d  = StWhiten;
      end
`ifdef CIPHER_BUS_SKID_EN
      else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = i_data;
        skid_ende_d  = i_ende;
        skid_mode_d  = i_key_mode;
      end else if (done && skid_valid_q) begin
        blk_d        = skid_data_q;
        ende_d       = skid_ende_q;
        nr_d         = nr_of(skid_mode_q);
        rnd_d        = 4'd0;
        fsm_d        = StWhiten;
        skid_valid_d = 1'b0;
      end
`endif
    end
`ifdef CIPHER_BUS_SKID_EN
    ready_d = !skid_valid_d && i_key_ready && mode_ok;
`else
    ready_d = (fsm_d == StIdle) && i_key_ready && mode_ok;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q        <= StIdle;
      rnd_q        <= 4'd0;
      blk_q        <= '0;
      ende_q       <= 1'b0;
      nr_q         <= 4'd10;
      o_ready      <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_abort      <= 1'b0;
`ifdef CIPHER_BUS_SKID_EN
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ende_q  <= 1'b0;
      skid_mode_q  <= 2'b00;
`endif
    end else begin
      fsm_q        <= fsm_d;
      rnd_q        <= rnd_d;
      blk_q        <= blk_d;
      ende_q       <= ende_d;
      nr_q         <= nr_d;
      o_ready      <= ready_d;
      o_data       <= data_d;
      o_data_valid <= valid_d;
      o_abort      <= abort_d;
`ifdef CIPHER_BUS_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ende_q  <= skid_ende_d;
      skid_mode_q  <= skid_mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_cipher_bus_responder.sv
// Directed bench for cipher_bus_responder: an AES round function and key store model are
// attached to the round/key ports, and FIPS-197 vectors are pushed through the bus.
module tb_cipher_bus_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] i_data;
  logic         i_data_valid, i_ende, i_enable, i_key_ready;
  logic [1:0]   i_key_mode;
  logic         o_ready, o_data_valid, o_abort;
  logic [127:0] o_data;
  logic [3:0]   o_key_idx;
  logic [127:0] i_round_key, o_rnd_state, i_rnd_result;
  logic         o_rnd_ende, o_rnd_last;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
`ifdef CIPHER_BUS_SKID_EN
  localparam int B_ACC = 1;
  localparam int B_DONE = 30;
`else
  localparam int B_ACC = 16;
  localparam int B_DONE = 31;
`endif

  int n_checks, n_fail;
  logic [7:0]   sbox [0:255];
  logic [7:0]   inv_sbox [0:255];
  logic [127:0] rk [0:14];
  logic [3:0]   keylog [0:31];

  always #5 clk = ~clk;

  cipher_bus_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_ende       (i_ende),
    .i_enable     (i_enable),
    .i_key_mode   (i_key_mode),
    .i_key_ready  (i_key_ready),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_abort      (o_abort),
    .o_key_idx    (o_key_idx),
    .i_round_key  (i_round_key),
    .o_rnd_state  (o_rnd_state),
    .o_rnd_ende   (o_rnd_ende),
    .o_rnd_last   (o_rnd_last),
    .i_rnd_result (i_rnd_result)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] o;
    if (inv) begin
      m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9;
    end else begin
      m[0] = 8'd2; m[1] = 8'd3; m[2] = 8'd1; m[3] = 8'd1;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], m[(j - i + 4) % 4]);
        o[127-32*c-8*i -: 8] = b;
      end
    end
    return o;
  endfunction

  // Encrypt: Sub/Shift/Mix then key; decrypt: InvShift/InvSub, key, then InvMix.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic dec, input logic last);
    logic [7:0]   a [16];
    logic [127:0] t;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = dec ? inv_sbox[a[r+4*((c+4-r)%4)]] : sbox[a[r+4*((c+r)%4)]];
    if (dec) begin
      t = t ^ k;
      if (!last) t = mix(t, 1'b1);
    end else begin
      if (!last) t = mix(t, 1'b0);
      t = t ^ k;
    end
    return t;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  assign i_round_key = (o_key_idx <= 4'd14) ? rk[o_key_idx] : 128'h0;
  always_comb i_rnd_result = aes_round(o_rnd_state, i_round_key, o_rnd_ende, o_rnd_last);

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k <= nr; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Offers one block and watches it; stall_at/drop_at are edge indices after accept (-1 = off).
  task automatic run_block(input logic [127:0] din, input logic ende, input logic [1:0] mode,
                           input int stall_at, input int drop_at,
                           output int lat, output logic [127:0] dout, output int nvalid,
                           output int nabort, output logic ready_at_valid,
                           output int ready_hi_keylow);
    int wait_cnt, e, limit;
    lat = -1; dout = '0; nvalid = 0; nabort = 0; ready_at_valid = 1'b0; ready_hi_keylow = 0;
    for (int i = 0; i < 32; i++) keylog[i] = 4'hf;
    i_key_mode = mode;
    i_ende     = ende;
    i_data     = din;
    wait_cnt   = 0;
    @(negedge clk);
    while (!o_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!o_ready) return;
    i_data_valid = 1'b1;
    @(posedge clk);
    #1 i_data_valid = 1'b0;
    i_data = '0;
    @(negedge clk);
    keylog[0] = o_key_idx;
    limit = (drop_at >= 0) ? drop_at + 6 : 40;
    e = 0;
    while (e < limit) begin
      if (e == stall_at) i_enable = 1'b0;
      if (e == stall_at + 3) i_enable = 1'b1;
      if (e == drop_at) i_key_ready = 1'b0;
      @(posedge clk);
      e++;
      @(negedge clk);
      if (e < 32) keylog[e] = o_key_idx;
      if (o_data_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = e;
          dout = o_data;
          ready_at_valid = o_ready;
        end
      end
      if (o_abort) nabort++;
      if (!i_key_ready && o_ready) ready_hi_keylow++;
      if (lat >= 0 && e >= lat + 3 && drop_at < 0) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", o_ready); end
    n_checks++; if (o_data !== 128'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", o_data); end
    n_checks++; if (o_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_data_valid); end
    n_checks++; if (o_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort got %b want 0", o_abort); end
    n_checks++; if (o_key_idx !== 4'd0) begin n_fail++; $display("FAIL reset_keyidx got %0d want 0", o_key_idx); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", o_ready); end
  endtask

  task automatic test_enc256();
    int lat, nv, na, hk, errs;
    logic [127:0] d;
    logic rv;
    set_key(K256, 8);
    run_block(PT, 1'b0, 2'b10, -1, -1, lat, d, nv, na, rv, hk);
    errs = 0;
    for (int e = 0; e <= 14; e++) if (keylog[e] !== 4'(e)) errs++;
    n_checks++; if (d !== CT256) begin n_fail++; $display("FAIL enc256_data got %h want %h", d, CT256); end
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL enc256_latency got %0d want 15", lat); end
    n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL enc256_valid_pulses got %0d want 1", nv); end
    n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL enc256_ready_with_valid got %b want 1", rv); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL enc256_keyidx_seq got %0d bad want 0", errs); end
  endtask

  task automatic test_dec256();
    int lat, nv, na, hk, errs;
    logic [127:0] d;
    logic rv;
    set_key(K256, 8);
    run_block(CT256, 1'b1, 2'b10, -1, -1, lat, d, nv, na, rv, hk);
    errs = 0;
    for (int e = 0; e <= 14; e++) if (keylog[e] !== 4'(14 - e)) errs++;
    n_checks++; if (d !== PT) begin n_fail++; $display("FAIL dec256_data got %h want %h", d, PT); end
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL dec256_latency got %0d want 15", lat); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL dec256_keyidx_seq got %0d bad want 0", errs); end
    i_ende = 1'b0;
  endtask

  task automatic test_enc128();
    int lat, nv, na, hk;
    logic [127:0] d;
    logic rv;
    set_key(K128, 4);
    run_block(PT, 1'b0, 2'b00, -1, -1, lat, d, nv, na, rv, hk);
    n_checks++; if (d !== CT128) begin n_fail++; $display("FAIL enc128_data got %h want %h", d, CT128); end
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL enc128_latency got %0d want 11", lat); end
    n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL enc128_valid_pulses got %0d want 1", nv); end
  endtask

  task automatic test_stall();
    int lat, nv, na, hk, errs;
    logic [127:0] d;
    logic rv;
    set_key(K256, 8);
    run_block(PT, 1'b0, 2'b10, 5, -1, lat, d, nv, na, rv, hk);
    errs = 0;
    for (int e = 5; e <= 8; e++) if (keylog[e] !== 4'd5) errs++;
    n_checks++; if (d !== CT256) begin n_fail++; $display("FAIL stall_data got %h want %h", d, CT256); end
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL stall_latency got %0d want 18", lat); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL stall_keyidx_frozen got %0d bad want 0", errs); end
  endtask

  task automatic test_key_drop();
    int lat, nv, na, hk, rdy_hi;
    logic [127:0] d;
    logic rv;
    set_key(K256, 8);
    run_block(PT, 1'b0, 2'b10, -1, 7, lat, d, nv, na, rv, hk);
    n_checks++; if (na !== 1) begin n_fail++; $display("FAIL drop_abort_pulses got %0d want 1", na); end
    n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL drop_valid_pulses got %0d want 0", nv); end
    n_checks++; if (hk !== 0) begin n_fail++; $display("FAIL drop_ready_while_keylow got %0d want 0", hk); end
    i_key_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready_restored got %b want 1", o_ready); end
    // Reserved mode: block offered while ready must be refused.
    i_key_mode = 2'b11;
    i_data = PT;
    i_data_valid = 1'b1;
    rdy_hi = 0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ready) rdy_hi++;
      if (o_data_valid) nv++;
    end
    i_data_valid = 1'b0;
    n_checks++; if (rdy_hi !== 0) begin n_fail++; $display("FAIL mode11_ready got %0d high want 0", rdy_hi); end
    n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL mode11_valid got %0d want 0", nv); end
    i_key_mode = 2'b10;
    @(negedge clk);
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mode11_ready_restored got %b want 1", o_ready); end
  endtask

  task automatic test_reset_midop();
    int nv, na;
    set_key(K256, 8);
    i_key_mode = 2'b10;
    i_data = PT;
    i_data_valid = 1'b1;
    @(posedge clk);
    #1 i_data_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nv = 0;
    na = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_data_valid) nv++;
      if (o_abort) na++;
    end
    n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL midreset_valid got %0d want 0", nv); end
    n_checks++; if (na !== 0) begin n_fail++; $display("FAIL midreset_abort got %0d want 0", na); end
    n_checks++; if (o_data !== 128'h0) begin n_fail++; $display("FAIL midreset_data got %h want 0", o_data); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", o_ready); end
  endtask

  task automatic test_back_to_back();
    int e, b_acc, first, second, wait_cnt;
    logic [127:0] d1, d2;
    logic rdy;
    set_key(K256, 8);
    i_key_mode = 2'b10;
    wait_cnt = 0;
    @(negedge clk);
    while (!o_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    i_data = PT;
    i_ende = 1'b0;
    i_data_valid = 1'b1;
    @(posedge clk);
    #1 i_data = CT256;
    i_ende = 1'b1;
    b_acc = -1; first = -1; second = -1; d1 = '0; d2 = '0;
    e = 0;
    @(negedge clk);
    rdy = o_ready;
    while (e < 45) begin
      @(posedge clk);
      e++;
      if (b_acc < 0 && rdy && i_data_valid) b_acc = e;
      @(negedge clk);
      if (b_acc >= 0) i_data_valid = 1'b0;
      rdy = o_ready;
      if (o_data_valid) begin
        if (first < 0) begin first = e; d1 = o_data; end
        else if (second < 0) begin second = e; d2 = o_data; end
      end
    end
    i_data_valid = 1'b0;
    i_ende = 1'b0;
    n_checks++; if (b_acc !== B_ACC) begin n_fail++; $display("FAIL b2b_second_accept_edge got %0d want %0d", b_acc, B_ACC); end
    n_checks++; if (first !== 15) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 15", first); end
    n_checks++; if (d1 !== CT256) begin n_fail++; $display("FAIL b2b_first_data got %h want %h", d1, CT256); end
    n_checks++; if (second !== B_DONE) begin n_fail++; $display("FAIL b2b_second_done got %0d want %0d", second, B_DONE); end
    n_checks++; if (d2 !== PT) begin n_fail++; $display("FAIL b2b_second_data got %h want %h", d2, PT); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset_n = 1'b0;
    i_data = '0;
    i_data_valid = 1'b0;
    i_ende = 1'b0;
    i_enable = 1'b1;
    i_key_mode = 2'b10;
    i_key_ready = 1'b1;
    build_sbox();
    set_key(K256, 8);
    test_reset();
    test_enc256();
    test_dec256();
    test_enc128();
    test_stall();
    test_key_drop();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
